// File: rtl/pl_pkg.sv
`default_nettype none
// ============================================================================
// Package    : pl_pkg
// Description: Shared types and constants for the pipeline data-memory
//              arbiter: FSM state encoding, read-owner encodings and the
//              data-width helper.
// Revision   : 1.0 - initial release
// ============================================================================
package pl_pkg;

  // Arbiter FSM states, explicitly encoded
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SPLIT_RD  = 2'd1,
    ST_EXT_FORCE = 2'd2
  } state_t;

  // Owner of an in-flight read (selects which return port gets the data)
  localparam logic OWN_PIPE = 1'b0;
  localparam logic OWN_EXT  = 1'b1;

  // Each RNS domain contributes one byte to the data word
  function automatic int data_wid(input int num_domains);
    return num_domains * 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pl_dmem_rd_return.sv
`default_nettype none
// ============================================================================
// Module     : pl_dmem_rd_return
// Description: Read-return path. Remembers who issued the read in the
//              previous cycle and steers the memory read data to the pipe
//              or external return port; both ports read zero when idle.
// Revision   : 1.0 - initial release
// ============================================================================
module pl_dmem_rd_return
  import pl_pkg::*;
#(
  parameter int DATA_WID = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_rd_i,
  input  logic                issue_owner_i,
  input  logic [DATA_WID-1:0] mem_rdata_i,
  output logic [DATA_WID-1:0] pipe_rdata_o,
  output logic                pipe_rvalid_o,
  output logic [DATA_WID-1:0] ext_rdata_o,
  output logic                ext_rvalid_o
);

  logic tag_valid_q, tag_valid_d;
  logic tag_owner_q, tag_owner_d;

  // Next tag is simply the read issued this cycle
  always_comb begin
    tag_valid_d = issue_rd_i;
    tag_owner_d = issue_owner_i;
  end

  // Tag register; reset drops any read that is still in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= 1'b0;
      tag_owner_q <= OWN_PIPE;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_owner_q <= tag_owner_d;
    end
  end

  // Steer returning data to its owner, zero otherwise (also held quiet in reset)
  always_comb begin
    pipe_rdata_o  = '0;
    pipe_rvalid_o = 1'b0;
    ext_rdata_o   = '0;
    ext_rvalid_o  = 1'b0;
    if (tag_valid_q && !reset) begin
      if (tag_owner_q == OWN_EXT) begin
        ext_rdata_o  = mem_rdata_i;
        ext_rvalid_o = 1'b1;
      end else begin
        pipe_rdata_o  = mem_rdata_i;
        pipe_rvalid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pl_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : pl_dmem_arbiter
// Description: Shares the single-port data memory between the EX-stage
//              load/store path and an external loader/debug port. The pipe
//              has priority; the external port is force-granted after
//              EXT_MAX_WAIT refusals. A simultaneous load+store from the
//              pipe is split over two cycles (write first, then read).
// Revision   : 1.0 - initial release
// ============================================================================
module pl_dmem_arbiter
  import pl_pkg::*;
#(
  parameter int NUM_DOMAINS  = 1,
  parameter int ADDR_WID     = 16,
  parameter int EXT_MAX_WAIT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipe_rd_en_i,
  input  logic                             pipe_wr_en_i,
  input  logic [ADDR_WID-1:0]              pipe_rd_addr_i,
  input  logic [ADDR_WID-1:0]              pipe_wr_addr_i,
  input  logic [data_wid(NUM_DOMAINS)-1:0] pipe_wdata_i,
  output logic                             pipe_stall_o,
  output logic [data_wid(NUM_DOMAINS)-1:0] pipe_rdata_o,
  output logic                             pipe_rvalid_o,
  input  logic                             ext_req_i,
  input  logic                             ext_we_i,
  input  logic [ADDR_WID-1:0]              ext_addr_i,
  input  logic [data_wid(NUM_DOMAINS)-1:0] ext_wdata_i,
  output logic                             ext_gnt_o,
  output logic [data_wid(NUM_DOMAINS)-1:0] ext_rdata_o,
  output logic                             ext_rvalid_o,
  output logic                             mem_en_o,
  output logic                             mem_we_o,
  output logic [ADDR_WID-1:0]              mem_addr_o,
  output logic [data_wid(NUM_DOMAINS)-1:0] mem_wdata_o,
  input  logic [data_wid(NUM_DOMAINS)-1:0] mem_rdata_i
);

  localparam int DW = data_wid(NUM_DOMAINS);
  // Counter must hold EXT_MAX_WAIT itself; keep at least one bit for the
  // degenerate EXT_MAX_WAIT==0 configuration.
  localparam int WAIT_W = (EXT_MAX_WAIT < 1) ? 1 : $clog2(EXT_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(EXT_MAX_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              pipe_req;
  logic              ext_due;
  logic              issue_owner;
  logic              issue_rd;

  assign pipe_req = pipe_rd_en_i | pipe_wr_en_i;
  // External port has been refused long enough and must win this cycle
  assign ext_due  = ext_req_i && (wait_q >= WAIT_MAX);
  assign wait_inc = (wait_q >= WAIT_MAX) ? WAIT_MAX : wait_q + WAIT_W'(1);
  assign issue_rd = mem_en_o & ~mem_we_o;

  // State and refusal-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Arbitration decision: next state, counter update and memory issue
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mem_en_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    pipe_stall_o = 1'b0;
    ext_gnt_o    = 1'b0;
    issue_owner  = OWN_PIPE;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (pipe_wr_en_i && pipe_rd_en_i) begin
            // Store goes first; the load follows in SPLIT_RD
            mem_en_o     = 1'b1;
            mem_we_o     = 1'b1;
            mem_addr_o   = pipe_wr_addr_i;
            mem_wdata_o  = pipe_wdata_i;
            pipe_stall_o = 1'b1;
            wait_d       = ext_req_i ? wait_inc : '0;
            state_d      = ST_SPLIT_RD;
          end else if (pipe_req && !ext_due) begin
            mem_en_o   = 1'b1;
            mem_we_o   = pipe_wr_en_i;
            mem_addr_o = pipe_wr_en_i ? pipe_wr_addr_i : pipe_rd_addr_i;
            if (pipe_wr_en_i) begin
              mem_wdata_o = pipe_wdata_i;
            end
            wait_d = ext_req_i ? wait_inc : '0;
          end else if (ext_req_i) begin
            // Either the port is idle for the pipe or ext is overdue;
            // a stalled pipe re-presents its request next cycle.
            mem_en_o     = 1'b1;
            mem_we_o     = ext_we_i;
            mem_addr_o   = ext_addr_i;
            if (ext_we_i) begin
              mem_wdata_o = ext_wdata_i;
            end
            ext_gnt_o    = 1'b1;
            pipe_stall_o = pipe_req;
            issue_owner  = OWN_EXT;
            wait_d       = '0;
          end else begin
            wait_d = '0;
          end
        end
        ST_SPLIT_RD: begin
          mem_en_o   = 1'b1;
          mem_addr_o = pipe_rd_addr_i;
          wait_d     = ext_req_i ? wait_inc : '0;
          state_d    = ST_IDLE;
        end
        ST_EXT_FORCE: begin
          // Never entered; recover to IDLE if it ever is
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  pl_dmem_rd_return #(
    .DATA_WID (DW)
  ) u_rd_return (
    .clk           (clk),
    .reset         (reset),
    .issue_rd_i    (issue_rd),
    .issue_owner_i (issue_owner),
    .mem_rdata_i   (mem_rdata_i),
    .pipe_rdata_o  (pipe_rdata_o),
    .pipe_rvalid_o (pipe_rvalid_o),
    .ext_rdata_o   (ext_rdata_o),
    .ext_rvalid_o  (ext_rvalid_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_pl_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_pl_dmem_arbiter
// Description: Self-checking bench for pl_dmem_arbiter (3 domains, 24-bit
//              data, EXT_MAX_WAIT=4) with a behavioural memory and an
//              arbitration/memory reference model for random traffic.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pl_dmem_arbiter;

  localparam int ND   = 3;
  localparam int AW   = 16;
  localparam int DW   = 24;
  localparam int MAXW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_rd_en, pipe_wr_en;
  logic [AW-1:0] pipe_rd_addr, pipe_wr_addr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic [DW-1:0] pipe_rdata;
  logic          pipe_rvalid;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt;
  logic [DW-1:0] ext_rdata;
  logic          ext_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] env_mem [0:65535];

  pl_dmem_arbiter #(
    .NUM_DOMAINS  (ND),
    .ADDR_WID     (AW),
    .EXT_MAX_WAIT (MAXW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_rd_en_i   (pipe_rd_en),
    .pipe_wr_en_i   (pipe_wr_en),
    .pipe_rd_addr_i (pipe_rd_addr),
    .pipe_wr_addr_i (pipe_wr_addr),
    .pipe_wdata_i   (pipe_wdata),
    .pipe_stall_o   (pipe_stall),
    .pipe_rdata_o   (pipe_rdata),
    .pipe_rvalid_o  (pipe_rvalid),
    .ext_req_i      (ext_req),
    .ext_we_i       (ext_we),
    .ext_addr_i     (ext_addr),
    .ext_wdata_i    (ext_wdata),
    .ext_gnt_o      (ext_gnt),
    .ext_rdata_o    (ext_rdata),
    .ext_rvalid_o   (ext_rvalid),
    .mem_en_o       (mem_en),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous memory, read data one cycle after issue
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) env_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= env_mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_rd_en = 1'b0; pipe_wr_en = 1'b0;
    pipe_rd_addr = '0; pipe_wr_addr = '0; pipe_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0005;
    ext_req = 1'b1; ext_addr = 16'h0006;
    tick(); tick(); #1;
    n_tests++;
    if ({pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid});
    end
    n_tests++;
    if ({pipe_rdata, ext_rdata} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h/%h expected 0/0", pipe_rdata, ext_rdata);
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_tests++;
    if ({pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_ctrl: got %b expected 00000", {pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid});
    end
  endtask

  task automatic test_ext_idle();
    // ext write 0x40 <= 0x7E with an idle pipe
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0040; ext_wdata = 24'h00007E;
    #1;
    n_tests++;
    if ({ext_gnt, pipe_stall, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b1011, 16'h0040, 24'h00007E}) begin
      n_fail++;
      $display("FAIL ext_wr_issue: got gnt/stall/en/we=%b addr=%h wd=%h expected 1011 0040 00007e",
               {ext_gnt, pipe_stall, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    ext_we = 1'b0;
    #1;
    n_tests++;
    if ({ext_gnt, pipe_stall, mem_en, mem_we, mem_addr} !== {4'b1010, 16'h0040}) begin
      n_fail++;
      $display("FAIL ext_rd_issue: got gnt/stall/en/we=%b addr=%h expected 1010 0040",
               {ext_gnt, pipe_stall, mem_en, mem_we}, mem_addr);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({ext_rvalid, ext_rdata, pipe_rvalid, pipe_rdata} !== {1'b1, 24'h00007E, 1'b0, 24'h0}) begin
      n_fail++;
      $display("FAIL ext_rd_return: got erv=%b erd=%h prv=%b prd=%h expected 1 00007e 0 000000",
               ext_rvalid, ext_rdata, pipe_rvalid, pipe_rdata);
    end
    tick(); #1;
    n_tests++;
    if ({ext_rvalid, pipe_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL ext_rvalid_pulse: got %b expected 00", {ext_rvalid, pipe_rvalid});
    end
  endtask

  task automatic test_pipe_load();
    pipe_wr_en = 1'b1; pipe_wr_addr = 16'h0010; pipe_wdata = 24'h0000A5;
    #1;
    n_tests++;
    if ({pipe_stall, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b011, 16'h0010, 24'h0000A5}) begin
      n_fail++;
      $display("FAIL pipe_store_issue: got stall/en/we=%b addr=%h wd=%h expected 011 0010 0000a5",
               {pipe_stall, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    idle_inputs();
    pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0010;
    #1;
    n_tests++;
    if ({pipe_stall, mem_en, mem_we, mem_addr} !== {3'b010, 16'h0010}) begin
      n_fail++;
      $display("FAIL pipe_load_issue: got stall/en/we=%b addr=%h expected 010 0010",
               {pipe_stall, mem_en, mem_we}, mem_addr);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({pipe_rvalid, pipe_rdata, ext_rvalid, pipe_stall} !== {1'b1, 24'h0000A5, 2'b00}) begin
      n_fail++;
      $display("FAIL pipe_load_return: got prv=%b prd=%h erv=%b stall=%b expected 1 0000a5 0 0",
               pipe_rvalid, pipe_rdata, ext_rvalid, pipe_stall);
    end
    tick(); #1;
    n_tests++;
    if (pipe_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL pipe_rvalid_pulse: got %b expected 0", pipe_rvalid);
    end
  endtask

  task automatic test_split();
    pipe_wr_en = 1'b1; pipe_rd_en = 1'b1;
    pipe_wr_addr = 16'h0020; pipe_rd_addr = 16'h0020; pipe_wdata = 24'h00003C;
    #1;
    n_tests++;
    if ({pipe_stall, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h0020, 24'h00003C}) begin
      n_fail++;
      $display("FAIL split_write: got stall/en/we=%b addr=%h wd=%h expected 111 0020 00003c",
               {pipe_stall, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick();
    #1;
    n_tests++;
    if ({pipe_stall, mem_en, mem_we, mem_addr} !== {3'b010, 16'h0020}) begin
      n_fail++;
      $display("FAIL split_read: got stall/en/we=%b addr=%h expected 010 0020",
               {pipe_stall, mem_en, mem_we}, mem_addr);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({pipe_rvalid, pipe_rdata, pipe_stall} !== {1'b1, 24'h00003C, 1'b0}) begin
      n_fail++;
      $display("FAIL split_return: got prv=%b prd=%h stall=%b expected 1 00003c 0",
               pipe_rvalid, pipe_rdata, pipe_stall);
    end
    tick();
  endtask

  task automatic test_ext_force();
    for (int round = 0; round < 2; round++) begin
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 16'h0040;
      for (int c = 1; c <= 5; c++) begin
        pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0200 + 16'(c);
        #1;
        n_tests++;
        if (c < 5) begin
          if ({ext_gnt, pipe_stall, mem_en, mem_addr} !== {3'b001, pipe_rd_addr}) begin
            n_fail++;
            $display("FAIL ext_refused r%0d c%0d: got gnt/stall/en=%b addr=%h expected 001 %h",
                     round, c, {ext_gnt, pipe_stall, mem_en}, mem_addr, pipe_rd_addr);
          end
        end else begin
          if ({ext_gnt, pipe_stall, mem_en, mem_we, mem_addr} !== {4'b1110, 16'h0040}) begin
            n_fail++;
            $display("FAIL ext_forced r%0d: got gnt/stall/en/we=%b addr=%h expected 1110 0040",
                     round, {ext_gnt, pipe_stall, mem_en, mem_we}, mem_addr);
          end
        end
        tick();
      end
      // stalled pipe re-presents its load; ext is done
      ext_req = 1'b0;
      #1;
      n_tests++;
      if ({ext_gnt, pipe_stall, mem_en, mem_addr, ext_rvalid, ext_rdata, pipe_rvalid} !==
          {3'b001, 16'h0205, 1'b1, 24'h00007E, 1'b0}) begin
        n_fail++;
        $display("FAIL ext_force_after r%0d: got gnt/stall/en=%b addr=%h erv=%b erd=%h prv=%b expected 001 0205 1 00007e 0",
                 round, {ext_gnt, pipe_stall, mem_en}, mem_addr, ext_rvalid, ext_rdata, pipe_rvalid);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wide_roundtrip();
    pipe_wr_en = 1'b1; pipe_wr_addr = 16'h0080; pipe_wdata = 24'h123456;
    tick();
    idle_inputs();
    pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0080;
    tick();
    idle_inputs();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0090; ext_wdata = 24'h123456;
    #1;
    n_tests++;
    if ({pipe_rvalid, pipe_rdata} !== {1'b1, 24'h123456}) begin
      n_fail++;
      $display("FAIL wide_pipe: got prv=%b prd=%h expected 1 123456", pipe_rvalid, pipe_rdata);
    end
    tick();
    ext_we = 1'b0; ext_wdata = '0;
    tick();
    ext_addr = 16'h0080;
    #1;
    n_tests++;
    if ({ext_rvalid, ext_rdata} !== {1'b1, 24'h123456}) begin
      n_fail++;
      $display("FAIL wide_ext: got erv=%b erd=%h expected 1 123456", ext_rvalid, ext_rdata);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({ext_rvalid, ext_rdata} !== {1'b1, 24'h123456}) begin
      n_fail++;
      $display("FAIL wide_cross: got erv=%b erd=%h expected 1 123456", ext_rvalid, ext_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_split();
    // reset while a load is in flight discards its return
    pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0010;
    tick();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_tests++;
    if ({pipe_rvalid, pipe_rdata, ext_rvalid} !== {1'b0, 24'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_inflight: got prv=%b prd=%h erv=%b expected 0 000000 0", pipe_rvalid, pipe_rdata, ext_rvalid);
    end
    tick();
    reset = 1'b0;
    pipe_wr_en = 1'b1; pipe_rd_en = 1'b1;
    pipe_wr_addr = 16'h0030; pipe_wdata = 24'h000055; pipe_rd_addr = 16'h0010;
    tick();
    // now in SPLIT_RD; reset hits with the split load pending
    reset = 1'b1;
    #1;
    n_tests++;
    if ({pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_split_ctrl: got %b expected 00000", {pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid});
    end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_tests++;
    if ({pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid, pipe_rdata} !== {5'b0, 24'h0}) begin
      n_fail++;
      $display("FAIL reset_split_after: got %b prd=%h expected 00000 000000",
               {pipe_stall, ext_gnt, mem_en, pipe_rvalid, ext_rvalid}, pipe_rdata);
    end
    tick();
    // back in IDLE: a plain load issues without stall
    pipe_rd_en = 1'b1; pipe_rd_addr = 16'h0030;
    #1;
    n_tests++;
    if ({pipe_stall, mem_en, mem_we, mem_addr} !== {3'b010, 16'h0030}) begin
      n_fail++;
      $display("FAIL reset_split_idle: got stall/en/we=%b addr=%h expected 010 0030",
               {pipe_stall, mem_en, mem_we}, mem_addr);
    end
    tick();
    idle_inputs();
    #1;
    n_tests++;
    if ({pipe_rvalid, pipe_rdata} !== {1'b1, 24'h000055}) begin
      n_fail++;
      $display("FAIL reset_split_data: got prv=%b prd=%h expected 1 000055", pipe_rvalid, pipe_rdata);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    int            m_wait;
    bit            m_split, hold_pipe, ext_pend;
    bit            exp_prv, exp_erv;
    logic [DW-1:0] exp_d;
    int            kind;
    bit            e_stall, e_gnt, a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    bit            preq;

    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 24'($urandom);
      pipe_wr_en = 1'b1; pipe_wr_addr = 16'h0100 + 16'(i); pipe_wdata = ref_mem[i];
      tick();
    end
    idle_inputs();
    tick();

    m_wait = 0; m_split = 0; hold_pipe = 0; ext_pend = 0;
    exp_prv = 0; exp_erv = 0; exp_d = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) tick();
      n_tests++;
      if ({pipe_rvalid, ext_rvalid} !== {exp_prv, exp_erv}) begin
        n_fail++;
        $display("FAIL rnd_rvalid cyc%0d: got %b expected %b", cyc, {pipe_rvalid, ext_rvalid}, {exp_prv, exp_erv});
      end
      n_tests++;
      if (pipe_rdata !== (exp_prv ? exp_d : 24'h0) || ext_rdata !== (exp_erv ? exp_d : 24'h0)) begin
        n_fail++;
        $display("FAIL rnd_rdata cyc%0d: got %h/%h expected %h/%h", cyc, pipe_rdata, ext_rdata,
                 exp_prv ? exp_d : 24'h0, exp_erv ? exp_d : 24'h0);
      end

      if (!hold_pipe) begin
        {pipe_rd_en, pipe_wr_en} = 2'($urandom_range(0, 3));
        pipe_rd_addr = 16'h0100 | 16'($urandom_range(0, 15));
        pipe_wr_addr = 16'h0100 | 16'($urandom_range(0, 15));
        pipe_wdata   = 24'($urandom);
      end
      if (!ext_pend) begin
        ext_req   = ($urandom_range(0, 2) == 0);
        ext_we    = 1'($urandom_range(0, 1));
        ext_addr  = 16'h0100 | 16'($urandom_range(0, 15));
        ext_wdata = 24'($urandom);
      end
      #1;

      // Reference decision for this cycle
      preq = pipe_rd_en || pipe_wr_en;
      e_stall = 0; e_gnt = 0; kind = 0; a_we = 0; a_addr = '0; a_data = '0;
      if (m_split) begin
        kind = 1; a_addr = pipe_rd_addr; m_split = 0;
        m_wait = ext_req ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
      end else if (pipe_rd_en && pipe_wr_en) begin
        kind = 1; a_we = 1; a_addr = pipe_wr_addr; a_data = pipe_wdata;
        e_stall = 1; m_split = 1;
        m_wait = ext_req ? ((m_wait < MAXW) ? m_wait + 1 : MAXW) : 0;
      end else if (preq && !(ext_req && m_wait >= MAXW)) begin
        kind = 1; a_we = pipe_wr_en;
        a_addr = pipe_wr_en ? pipe_wr_addr : pipe_rd_addr; a_data = pipe_wdata;
        m_wait = ext_req ? m_wait + 1 : 0;
      end else if (ext_req) begin
        kind = 2; e_gnt = 1; e_stall = preq;
        a_we = ext_we; a_addr = ext_addr; a_data = ext_wdata;
        m_wait = 0;
      end else begin
        m_wait = 0;
      end

      n_tests++;
      if ({pipe_stall, ext_gnt, mem_en} !== {e_stall, e_gnt, kind != 0}) begin
        n_fail++;
        $display("FAIL rnd_ctrl cyc%0d: got stall/gnt/en=%b expected %b", cyc,
                 {pipe_stall, ext_gnt, mem_en}, {e_stall, e_gnt, kind != 0});
      end
      if (kind != 0) begin
        n_tests++;
        if ({mem_we, mem_addr} !== {a_we, a_addr} || (a_we && mem_wdata !== a_data)) begin
          n_fail++;
          $display("FAIL rnd_access cyc%0d: got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h", cyc,
                   mem_we, mem_addr, mem_wdata, a_we, a_addr, a_data);
        end
      end

      exp_prv = (kind == 1) && !a_we;
      exp_erv = (kind == 2) && !a_we;
      if (kind != 0) begin
        if (a_we) ref_mem[a_addr[3:0]] = a_data;
        else      exp_d = ref_mem[a_addr[3:0]];
      end
      hold_pipe = e_stall;
      ext_pend  = ext_req && !e_gnt;
    end
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_ext_idle();
    test_pipe_load();
    test_split();
    test_ext_force();
    test_wide_roundtrip();
    test_reset_mid_split();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
